// File: rtl/flash_pkg.sv
// Shared types and defaults for flash read clients.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flash_pkg;

  localparam int FLASH_ADDR_W = 23;  // flash word address, not byte address
  localparam int FLASH_DATA_W = 32;

  // Every flash read fetches a whole word, so each byte lane is enabled.
  localparam logic FLASH_BE_BIT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_VALID,
    ST_DONE,
    ST_RELEASE
  } flash_rd_state_e;

endpackage

// File: rtl/timeout_counter.sv
// Saturating cycle counter with a terminal-count flag, for bounding bus waits.
// Latency: tc rises LIMIT-1 enabled cycles after clr; clr takes effect next cycle.
// Backpressure: none; counts whenever en is high and holds at LIMIT-1.
//
// Ports: clk, reset (async, active-low), clr (sync clear, wins over en),
//        en (count enable), tc (count has reached LIMIT-1).
module timeout_counter #(
  parameter int LIMIT = 1024  // must be >= 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int               CNT_W  = $clog2(LIMIT);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TC_VAL)) begin
      // Saturate at the terminal value instead of wrapping back to zero.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/flash_read_ctrl.sv
// Single-word flash reader: level request in, one Avalon-MM pipelined read out, done pulse back.
// Latency: 3 cycles from start_read sampled to read_done_flag with zero wait and 1-cycle data.
// Backpressure: holds the read strobe while waitrequest is high; timeout aborts with a zero word.
//
// Ports: clk, reset (async, active-low)
//   requester side: start_read, read_address -> flash_data, read_done_flag, read_error, busy
//   Avalon side:    flash_mem_read/address/byteenable -> waitrequest, readdata, readdatavalid
module flash_read_ctrl
  import flash_pkg::*;
#(
  parameter int ADDR_W         = FLASH_ADDR_W,
  parameter int DATA_W         = FLASH_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_read,
  input  logic [ADDR_W-1:0]   read_address,
  output logic [DATA_W-1:0]   flash_data,
  output logic                read_done_flag,
  output logic                read_error,
  output logic                busy,
  output logic                flash_mem_read,
  output logic [ADDR_W-1:0]   flash_mem_address,
  output logic [DATA_W/8-1:0] flash_mem_byteenable,
  input  logic                flash_mem_waitrequest,
  input  logic [DATA_W-1:0]   flash_mem_readdata,
  input  logic                flash_mem_readdatavalid
);

  flash_rd_state_e   state_q,      state_d;
  logic [DATA_W-1:0] flash_data_q, flash_data_d;
  logic              done_q,       done_d;
  logic              error_q,      error_d;
  logic              rd_q,         rd_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

  // The counter restarts on every accepted request and only runs while the
  // bus transaction is outstanding.
  assign cnt_clr = (state_q == ST_IDLE) && start_read;
  assign cnt_en  = (state_q == ST_ISSUE) || (state_q == ST_WAIT_VALID);

  timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    flash_data_d = flash_data_q;
    done_d       = 1'b0;
    error_d      = error_q;
    rd_d         = rd_q;
    addr_d       = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start_read) begin
          addr_d  = read_address;
          error_d = 1'b0;
          rd_d    = 1'b1;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (cnt_tc) begin
          rd_d         = 1'b0;
          flash_data_d = '0;
          error_d      = 1'b1;
          done_d       = 1'b1;
          state_d      = ST_DONE;
        end else if (!flash_mem_waitrequest) begin
          // Command accepted at this edge; strobe drops so only one read is issued.
          rd_d    = 1'b0;
          state_d = ST_WAIT_VALID;
        end
      end

      ST_WAIT_VALID: begin
        // Data arriving in the timeout cycle still counts as a good read.
        if (flash_mem_readdatavalid) begin
          flash_data_d = flash_mem_readdata;
          done_d       = 1'b1;
          state_d      = ST_DONE;
        end else if (cnt_tc) begin
          flash_data_d = '0;
          error_d      = 1'b1;
          done_d       = 1'b1;
          state_d      = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        // Requester holds start_read until it sees done; wait for it to drop
        // so the same request is not served twice.
        if (!start_read) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        rd_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      flash_data_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      flash_data_q <= flash_data_d;
      done_q       <= done_d;
      error_q      <= error_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
    end
  end

  assign flash_data           = flash_data_q;
  assign read_done_flag       = done_q;
  assign read_error           = error_q;
  assign flash_mem_read       = rd_q;
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = {(DATA_W/8){FLASH_BE_BIT}};
  assign busy                 = (state_q != ST_IDLE);

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Directed bench for flash_read_ctrl with a behavioural Avalon slave.
// Latency: slave stall and read latency are configurable per scenario.
// Backpressure: slave asserts waitrequest for slave_stall cycles per read.
module tb_flash_read_ctrl;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start_read = 1'b0;
  logic [AW-1:0]   read_address = '0;
  logic [DW-1:0]   flash_data;
  logic            read_done_flag;
  logic            read_error;
  logic            busy;
  logic            flash_mem_read;
  logic [AW-1:0]   flash_mem_address;
  logic [DW/8-1:0] flash_mem_byteenable;
  logic            flash_mem_waitrequest = 1'b0;
  logic [DW-1:0]   flash_mem_readdata = '0;
  logic            flash_mem_readdatavalid = 1'b0;

  int tests = 0;
  int fails = 0;

  // Slave configuration and state
  int            slave_stall = 0;
  int            slave_lat = 1;
  logic          slave_drop = 1'b0;
  logic          slave_ovr_en = 1'b0;
  logic [DW-1:0] slave_ovr_dat = '0;
  int            stall_left = 0;
  int            lat_left = 0;
  logic          pend = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  int            accept_cnt = 0;
  int            done_cnt = 0;

  flash_read_ctrl #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .start_read              (start_read),
    .read_address            (read_address),
    .flash_data              (flash_data),
    .read_done_flag          (read_done_flag),
    .read_error              (read_error),
    .busy                    (busy),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[7:0], 1'b1, a} ^ 32'h5A5A_0000;
  endfunction

  // Slave drives its inputs on the falling edge for the next rising edge.
  always @(negedge clk) begin
    flash_mem_readdatavalid = 1'b0;
    if (pend) begin
      if (lat_left == 0) begin
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = slave_ovr_en ? slave_ovr_dat : mem_word(pend_addr);
        pend                    = 1'b0;
      end else begin
        lat_left--;
      end
    end
    if (flash_mem_read) begin
      if (stall_left > 0) begin
        flash_mem_waitrequest = 1'b1;
        stall_left--;
      end else begin
        flash_mem_waitrequest = 1'b0;
        accept_cnt++;
        if (!slave_drop) begin
          pend      = 1'b1;
          lat_left  = slave_lat - 1;
          pend_addr = flash_mem_address;
        end
      end
    end else begin
      flash_mem_waitrequest = 1'b0;
      stall_left            = slave_stall;
    end
  end

  always @(negedge clk) begin
    if (read_done_flag) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (read_done_flag === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start_read = 1'b0;
    repeat (3) tick();
    tests++;
    if (busy !== 1'b0 || flash_mem_read !== 1'b0 || read_done_flag !== 1'b0 || read_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: busy=%b rd=%b done=%b err=%b, required all 0",
               busy, flash_mem_read, read_done_flag, read_error);
    end
    tests++;
    if (flash_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got %h required 0", flash_data);
    end
    tests++;
    if (flash_mem_address !== 23'h0) begin
      fails++;
      $display("FAIL reset_addr: got %h required 0", flash_mem_address);
    end
    tests++;
    if (flash_mem_byteenable !== 4'hF) begin
      fails++;
      $display("FAIL byteenable: got %h required f", flash_mem_byteenable);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_zero_wait();
    slave_stall   = 0;
    slave_lat     = 1;
    slave_ovr_en  = 1'b1;
    slave_ovr_dat = 32'hDEADBEEF;
    read_address  = 23'h000123;
    start_read    = 1'b1;
    tick();  // edge 0: request taken
    tests++;
    if (flash_mem_read !== 1'b1 || flash_mem_address !== 23'h000123 || busy !== 1'b1 || read_done_flag !== 1'b0) begin
      fails++;
      $display("FAIL zw_issue: rd=%b addr=%h busy=%b done=%b, required 1/000123/1/0",
               flash_mem_read, flash_mem_address, busy, read_done_flag);
    end
    tick();  // edge 1: accepted
    tests++;
    if (flash_mem_read !== 1'b0 || read_done_flag !== 1'b0) begin
      fails++;
      $display("FAIL zw_accept: rd=%b done=%b, required 0/0", flash_mem_read, read_done_flag);
    end
    tick();  // edge 2: data returned
    tests++;
    if (read_done_flag !== 1'b1) begin
      fails++;
      $display("FAIL zw_done_latency: done=%b required 1 at third cycle", read_done_flag);
    end
    tests++;
    if (flash_data !== 32'hDEADBEEF || read_error !== 1'b0) begin
      fails++;
      $display("FAIL zw_data: data=%h err=%b, required deadbeef/0", flash_data, read_error);
    end
    start_read = 1'b0;
    tick();
    tests++;
    if (read_done_flag !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL zw_pulse_release: done=%b busy=%b, required 0/1", read_done_flag, busy);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || flash_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL zw_idle: busy=%b data=%h, required 0/deadbeef", busy, flash_data);
    end
    slave_ovr_en = 1'b0;
  endtask

  task automatic test_stalled_accept();
    int  acc0;
    int  hi;
    bit  stable;
    acc0         = accept_cnt;
    hi           = 0;
    stable       = 1'b1;
    slave_stall  = 4;
    slave_lat    = 1;
    read_address = 23'h0A5A5A;
    start_read   = 1'b1;
    tick();  // edge 0
    for (int i = 0; i < 5; i++) begin
      if (flash_mem_read !== 1'b1 || flash_mem_address !== 23'h0A5A5A) stable = 1'b0;
      tick();
    end
    tests++;
    if (!stable) begin
      fails++;
      $display("FAIL stall_stable: read/address changed during stall, required held 5 cycles");
    end
    tests++;
    if (flash_mem_read !== 1'b0) begin
      fails++;
      $display("FAIL stall_drop: rd=%b after accept, required 0", flash_mem_read);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (read_done_flag === 1'b1) begin
        hi++;
        start_read = 1'b0;
      end
    end
    tests++;
    if (hi != 1 || (accept_cnt - acc0) != 1) begin
      fails++;
      $display("FAIL stall_single: done_cycles=%0d accepts=%0d, required 1/1", hi, accept_cnt - acc0);
    end
    tests++;
    if (flash_data !== mem_word(23'h0A5A5A) || busy !== 1'b0) begin
      fails++;
      $display("FAIL stall_data: data=%h busy=%b, required %h/0", flash_data, busy, mem_word(23'h0A5A5A));
    end
    slave_stall = 0;
  endtask

  task automatic test_held_start();
    bit ok;
    int acc0;
    bit quiet;
    read_address = 23'h000055;
    start_read   = 1'b1;
    wait_done(20, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL held_first_done: no done pulse within 20 cycles");
    end
    acc0  = accept_cnt;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (flash_mem_read !== 1'b0 || busy !== 1'b1) quiet = 1'b0;
    end
    tests++;
    if (!quiet || accept_cnt != acc0) begin
      fails++;
      $display("FAIL held_no_retrigger: quiet=%b extra_accepts=%0d, required 1/0", quiet, accept_cnt - acc0);
    end
    start_read = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL held_release: busy=%b after start drop, required 0", busy);
    end
    read_address = 23'h7FFFFF;
    start_read   = 1'b1;
    tick();
    tests++;
    if (flash_mem_read !== 1'b1 || flash_mem_address !== 23'h7FFFFF) begin
      fails++;
      $display("FAIL held_rereq: rd=%b addr=%h, required 1/7fffff", flash_mem_read, flash_mem_address);
    end
    wait_done(20, ok);
    tests++;
    if (!ok || flash_data !== mem_word(23'h7FFFFF)) begin
      fails++;
      $display("FAIL held_rereq_data: done=%b data=%h, required 1/%h", ok, flash_data, mem_word(23'h7FFFFF));
    end
    start_read = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    bit early;
    bit ok;
    slave_drop   = 1'b1;
    read_address = 23'h000200;
    start_read   = 1'b1;
    tick();  // edge 0
    early = 1'b0;
    for (int k = 1; k < TO; k++) begin
      tick();
      if (read_done_flag !== 1'b0) early = 1'b1;
    end
    tests++;
    if (early) begin
      fails++;
      $display("FAIL to_early: done pulse before cycle %0d, required none", TO);
    end
    tick();  // edge TO
    tests++;
    if (read_done_flag !== 1'b1) begin
      fails++;
      $display("FAIL to_done: done=%b at cycle %0d, required 1", read_done_flag, TO);
    end
    tests++;
    if (flash_data !== 32'h0 || read_error !== 1'b1) begin
      fails++;
      $display("FAIL to_result: data=%h err=%b, required 0/1", flash_data, read_error);
    end
    start_read = 1'b0;
    tick();
    tick();
    tests++;
    if (busy !== 1'b0 || read_error !== 1'b1) begin
      fails++;
      $display("FAIL to_sticky: busy=%b err=%b, required 0/1", busy, read_error);
    end
    slave_drop   = 1'b0;
    read_address = 23'h000201;
    start_read   = 1'b1;
    tick();
    tests++;
    if (read_error !== 1'b0) begin
      fails++;
      $display("FAIL to_clear: err=%b after new request, required 0", read_error);
    end
    wait_done(20, ok);
    tests++;
    if (!ok || flash_data !== mem_word(23'h000201) || read_error !== 1'b0) begin
      fails++;
      $display("FAIL to_recover: done=%b data=%h err=%b, required 1/%h/0",
               ok, flash_data, read_error, mem_word(23'h000201));
    end
    start_read = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    bit bad;
    slave_lat     = 4;
    slave_ovr_en  = 1'b1;
    slave_ovr_dat = 32'h12345678;
    read_address  = 23'h000300;
    start_read    = 1'b1;
    tick();
    tick();
    tests++;
    if (busy !== 1'b1 || flash_mem_read !== 1'b0) begin
      fails++;
      $display("FAIL ar_wait_state: busy=%b rd=%b, required 1/0", busy, flash_mem_read);
    end
    #2;
    reset      = 1'b0;
    start_read = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || flash_mem_read !== 1'b0 || flash_mem_address !== 23'h0 ||
        flash_data !== 32'h0 || read_done_flag !== 1'b0 || read_error !== 1'b0) begin
      fails++;
      $display("FAIL ar_immediate: busy=%b rd=%b addr=%h data=%h done=%b err=%b, required all 0",
               busy, flash_mem_read, flash_mem_address, flash_data, read_done_flag, read_error);
    end
    tick();
    reset = 1'b1;
    bad   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (read_done_flag !== 1'b0 || flash_data !== 32'h0 || busy !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL ar_late_valid: done=%b data=%h busy=%b, required 0/0/0",
               read_done_flag, flash_data, busy);
    end
    slave_ovr_en = 1'b0;
    slave_lat    = 1;
  endtask

  task automatic test_back_to_back();
    int            acc0;
    int            d0;
    bit            ok;
    logic [AW-1:0] a;
    acc0 = accept_cnt;
    d0   = done_cnt;
    for (int i = 0; i < 8; i++) begin
      a            = 23'h001000 + AW'(i);
      slave_stall  = i % 3;
      slave_lat    = 1 + (i % 2);
      read_address = a;
      start_read   = 1'b1;
      wait_done(30, ok);
      tests++;
      if (!ok || flash_data !== mem_word(a)) begin
        fails++;
        $display("FAIL b2b_word%0d: done=%b data=%h, required 1/%h", i, ok, flash_data, mem_word(a));
      end
      start_read = 1'b0;
      for (int k = 0; k < 5 && busy !== 1'b0; k++) tick();
    end
    tests++;
    if ((accept_cnt - acc0) != 8 || (done_cnt - d0) != 8) begin
      fails++;
      $display("FAIL b2b_counts: accepts=%0d dones=%0d, required 8/8", accept_cnt - acc0, done_cnt - d0);
    end
    slave_stall = 0;
    slave_lat   = 1;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stalled_accept();
    test_held_start();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/flash_read_ctrl.md
Name: flash_read_ctrl

Overview:
Responder side of the flash-word read handshake. Accepts a level-held read request plus word address from the audio address counter, runs one Avalon-MM pipelined read on the flash controller port, latches the 32-bit word and returns a one-cycle done pulse. A bounded timeout returns a silent (zero) word and flags an error, so audio playback never hangs.

Parameters:
ADDR_W, 23, word-address width (flash word address, not byte address)
DATA_W, 32, flash data word width
TIMEOUT_CYCLES, 1024, max cycles spent in ISSUE+WAIT_VALID before abort (must be >= 2)

Ports:
clk  in  1  system clock (50 MHz domain)
reset  in  1  asynchronous, active-low reset
start_read  in  1  level request from requester; held high until read_done_flag seen
read_address  in  ADDR_W  word address; sampled only on request acceptance
flash_data  out  DATA_W  latched read word; stable from done pulse until next acceptance
read_done_flag  out  1  one-cycle pulse, data valid
read_error  out  1  sticky timeout flag; cleared on next accepted request
busy  out  1  high in any state other than IDLE
flash_mem_read  out  1  Avalon read strobe
flash_mem_address  out  ADDR_W  Avalon word address
flash_mem_byteenable  out  DATA_W/8  constant all-ones
flash_mem_waitrequest  in  1  Avalon stall
flash_mem_readdata  in  DATA_W  Avalon read data
flash_mem_readdatavalid  in  1  Avalon data strobe

Behaviour:
- Reset (reset low, async): state=IDLE; flash_data=0; read_done_flag=0; read_error=0; flash_mem_read=0; flash_mem_address=0; timeout counter=0. Reset mid-transaction abandons the read; any readdatavalid arriving afterwards is ignored in IDLE.
- States: IDLE, ISSUE, WAIT_VALID, DONE, RELEASE.
- IDLE: when start_read=1, latch read_address into flash_mem_address, clear read_error and timeout counter, go to ISSUE.
- ISSUE: flash_mem_read=1 and flash_mem_address held constant. At an edge with waitrequest=0 the command is accepted: go to WAIT_VALID and drop flash_mem_read in that cycle. Never issue a second read.
- WAIT_VALID: on readdatavalid=1, latch readdata into flash_data and go to DONE. readdatavalid outside WAIT_VALID is ignored.
- DONE: read_done_flag=1 for exactly this cycle, then go to RELEASE.
- RELEASE: wait for start_read=0, then go to IDLE. This stops a still-high start_read from re-triggering a read. A new request is accepted no earlier than the cycle after start_read is seen low.
- Timeout: the counter increments every cycle in ISSUE/WAIT_VALID. When it reaches TIMEOUT_CYCLES-1 with no completion: flash_mem_read=0, flash_data=0, read_error=1, go to DONE (normal done pulse). If readdatavalid and timeout occur in the same cycle, the data wins and no error is raised.
- Minimum latency: start_read sampled at edge 0 -> read asserted; accept at edge 1; valid at edge 2 -> read_done_flag high in cycle after edge 2 (3 cycles). Throughput is one word per 5 cycles minimum, including RELEASE.
- Counter width is $clog2(TIMEOUT_CYCLES). The counter saturates and does not wrap.
- Outputs are registered except busy, which decodes from the state.

Decomposition:
- Shared package flash_pkg: state enum type, ADDR_W/DATA_W defaults, byteenable constant.
- One natural sub-module: timeout_counter (clear, enable, terminal-count output, parameterised limit). It is reusable by other flash clients.

Test Plan:
- Zero-wait read: addr 23'h000123; slave waitrequest=0, valid 1 cycle after accept with 32'hDEADBEEF -> flash_mem_address=23'h000123, done pulse exactly 3 cycles after start, flash_data=32'hDEADBEEF, read_error=0.
- Stalled accept: waitrequest held high 4 cycles -> flash_mem_read and address stable all 5 cycles, single accept, done pulse width 1.
- Held start: start_read kept high 6 cycles after done -> no second flash_mem_read until start drops; re-raise with addr 23'h7FFFFF -> new read at that address.
- Timeout: TIMEOUT_CYCLES=16, slave never returns valid -> done pulse at cycle 16 of ISSUE/WAIT_VALID, flash_data=0, read_error=1. Next good read clears read_error.
- Async reset asserted in WAIT_VALID, late readdatavalid with 32'h12345678 -> outputs at reset values, flash_data stays 0, no done pulse.
- Back-to-back requester model emulating address counter, 8 sequential words -> 8 done pulses, data in address order, no dropped or duplicated reads.
